// File: rtl/hangman_pkg.sv
// Shared constants, receiver state encoding and the scan-code-set-2 make-code map
// for the hangman keyboard front end.
package hangman_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_NONE   = 8'h00;
    localparam logic [4:0] KEY_START = 5'd26;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef struct packed {
        logic       hit;
        logic [4:0] idx;
    } key_map_t;

    function automatic key_map_t map_make_code(input logic [7:0] sc);
        key_map_t k;
        k.hit = 1'b1;
        k.idx = 5'd0;
        case (sc)
            8'h1C: k.idx = 5'd0;
            8'h32: k.idx = 5'd1;
            8'h21: k.idx = 5'd2;
            8'h23: k.idx = 5'd3;
            8'h24: k.idx = 5'd4;
            8'h2B: k.idx = 5'd5;
            8'h34: k.idx = 5'd6;
            8'h33: k.idx = 5'd7;
            8'h43: k.idx = 5'd8;
            8'h3B: k.idx = 5'd9;
            8'h42: k.idx = 5'd10;
            8'h4B: k.idx = 5'd11;
            8'h3A: k.idx = 5'd12;
            8'h31: k.idx = 5'd13;
            8'h44: k.idx = 5'd14;
            8'h4D: k.idx = 5'd15;
            8'h15: k.idx = 5'd16;
            8'h2D: k.idx = 5'd17;
            8'h1B: k.idx = 5'd18;
            8'h2C: k.idx = 5'd19;
            8'h3C: k.idx = 5'd20;
            8'h2A: k.idx = 5'd21;
            8'h1D: k.idx = 5'd22;
            8'h22: k.idx = 5'd23;
            8'h35: k.idx = 5'd24;
            8'h1A: k.idx = 5'd25;
            SC_ENTER: k.idx = KEY_START;
            default: k.hit = 1'b0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronize + glitch-filter both lines, sample data on filtered
// clock falling edges, watchdog on stalled frames. Optional PS2_PARITY_CHECK_EN adds odd-parity check.
module ps2_rx
    import hangman_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [FW-1:0] FLT_ONE  = FW'(1);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [WW-1:0] WD_ONE   = WW'(1);

    // bit 0 = clock, bit 1 = data
    logic [1:0]         sync1;
    logic [1:0]         sync2;
    logic [1:0]         filt;
    logic [1:0][FW-1:0] flt_cnt;
    logic               clk_prev;
    logic               strobe;
    logic               data_f;

    rx_state_t          state;
    rx_state_t          state_nxt;
    logic [2:0]         bit_cnt;
    logic [7:0]         shreg;
    logic [WW-1:0]      wd_cnt;
    logic               timeout;
    logic               par_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= 2'b11;
            sync2    <= 2'b11;
            filt     <= 2'b11;
            flt_cnt  <= '0;
            clk_prev <= 1'b1;
        end else begin
            sync1    <= {ps2_data, ps2_clk};
            sync2    <= sync1;
            clk_prev <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == FLT_LAST) begin
                    filt[i]    <= sync2[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + FLT_ONE;
                end
            end
        end
    end

    assign strobe  = clk_prev & ~filt[0];
    assign data_f  = filt[1];
    assign rx_byte = shreg;
    assign timeout = (state != RX_IDLE) && !strobe && (wd_cnt == WD_LAST);

`ifdef PS2_PARITY_CHECK_EN
    logic par_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_bit <= 1'b0;
        end else if (strobe && state == RX_PARITY) begin
            par_bit <= data_f;
        end
    end

    assign par_ok = ^{shreg, par_bit};
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rx_valid  = 1'b0;
        rx_err    = 1'b0;
        if (timeout) begin
            state_nxt = RX_IDLE;
            rx_err    = 1'b1;
        end else if (strobe) begin
            case (state)
                RX_IDLE:   if (!data_f) state_nxt = RX_DATA;
                RX_DATA:   if (bit_cnt == 3'd7) state_nxt = RX_PARITY;
                RX_PARITY: state_nxt = RX_STOP;
                RX_STOP: begin
                    state_nxt = RX_IDLE;
                    if (data_f && par_ok) rx_valid = 1'b1;
                    else                  rx_err   = 1'b1;
                end
                default:   state_nxt = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= 3'd0;
            shreg   <= 8'h00;
            wd_cnt  <= '0;
        end else begin
            if (state == RX_IDLE) begin
                bit_cnt <= 3'd0;
            end else if (strobe && state == RX_DATA) begin
                shreg   <= {data_f, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            wd_cnt <= (state == RX_IDLE || strobe) ? '0 : wd_cnt + WD_ONE;
        end
    end

endmodule

// File: rtl/keyboard_letter_decoder.sv
// Turns PS/2 make codes for A-Z/Enter into one-cycle load pulses; break/extended prefixes
// and typematic repeats are swallowed. Parity checking is enabled by PS2_PARITY_CHECK_EN.
module keyboard_letter_decoder
    import hangman_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       load,
    output logic [4:0] load_x,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;
    logic [7:0] held_key;
    logic       brk_pend;
    logic       ext_pend;
    key_map_t   key;

    ps2_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_err   (rx_err)
    );

    assign key = map_make_code(rx_byte);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load      <= 1'b0;
            frame_err <= 1'b0;
            load_x    <= 5'd0;
            held_key  <= SC_NONE;
            brk_pend  <= 1'b0;
            ext_pend  <= 1'b0;
        end else begin
            load      <= 1'b0;
            frame_err <= rx_err;
            if (rx_valid) begin
                if (rx_byte == SC_BREAK) begin
                    brk_pend <= 1'b1;
                end else if (rx_byte == SC_EXT) begin
                    ext_pend <= 1'b1;
                end else if (brk_pend) begin
                    if (rx_byte == held_key) held_key <= SC_NONE;
                    brk_pend <= 1'b0;
                    ext_pend <= 1'b0;
                end else if (ext_pend) begin
                    ext_pend <= 1'b0;
                end else if (key.hit && rx_byte != held_key) begin
                    // a held key re-sends its make code; only a new key counts as a guess
                    load     <= 1'b1;
                    load_x   <= key.idx;
                    held_key <= rx_byte;
                end
            end
        end
    end

endmodule

// File: tb/tb_keyboard_letter_decoder.sv
// Drives PS/2 frames (directed cases then random traffic) and compares load/load_x/frame_err
// against a byte-level model of the key-event rules.
module tb_keyboard_letter_decoder;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 2000;
    localparam int HALF       = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       load;
    logic [4:0] load_x;
    logic       frame_err;

    always #5 clk = ~clk;

    keyboard_letter_decoder #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .load      (load),
        .load_x    (load_x),
        .frame_err (frame_err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int loads_seen    = 0;
    int errs_seen     = 0;
    int last_load_cyc = 0;
    int stop_cyc      = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (load) begin
            loads_seen++;
            last_load_cyc = cyc;
            chk("x_range", 32'(load_x <= 5'd26), 1);
        end
        if (frame_err) errs_seen++;
        if (load || frame_err) chk("excl", 32'(load & frame_err), 0);
    end

    // ---------------- reference model ----------------
    logic [7:0] codes [27] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                               8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                               8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                               8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A, 8'h5A};
    logic [7:0] m_held;
    bit         m_brk;
    bit         m_ext;
    int         m_x;

    function automatic int key_of(input logic [7:0] b);
        for (int i = 0; i < 27; i++) if (codes[i] == b) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_held = 8'h00;
        m_brk  = 0;
        m_ext  = 0;
        m_x    = 0;
    endtask

    task automatic model(input logic [7:0] b, input bit ok, output int e_load, output int e_err);
        int k;
        e_load = 0;
        e_err  = ok ? 0 : 1;
        if (!ok) return;
        k = key_of(b);
        if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else if (m_brk) begin
            if (b == m_held) m_held = 8'h00;
            m_brk = 0;
            m_ext = 0;
        end else if (m_ext) m_ext = 0;
        else if (k >= 0 && b != m_held) begin
            e_load = 1;
            m_x    = k;
            m_held = b;
        end
    endtask

    // ---------------- PS/2 driver ----------------
    task automatic ps2_bit(input logic v, input bit mark);
        ps2_data = v;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        if (mark) stop_cyc = cyc;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input bit flip);
        logic par;
        par = ~(^b) ^ flip;
        ps2_bit(1'b0, 0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 0);
        ps2_bit(par, 0);
        ps2_bit(stop, 1);
        ps2_data = 1'b1;
    endtask

    task automatic do_frame(input string tag, input logic [7:0] b, input logic stop, input bit flip);
        int  e_load, e_err, l0, e0;
        bit  ok;
        ok = stop;
`ifdef PS2_PARITY_CHECK_EN
        if (flip) ok = 0;
`endif
        model(b, ok, e_load, e_err);
        l0 = loads_seen;
        e0 = errs_seen;
        send_frame(b, stop, flip);
        chk({tag, ".load"}, loads_seen - l0, e_load);
        chk({tag, ".err"}, errs_seen - e0, e_err);
        chk({tag, ".x"}, 32'(load_x), m_x);
        if (e_load == 1 && loads_seen - l0 == 1) begin
            chk({tag, ".lat"},
                32'((last_load_cyc - stop_cyc) >= FILTER_LEN + 1 &&
                    (last_load_cyc - stop_cyc) <= FILTER_LEN + 4), 1);
        end
    endtask

    initial begin
        int l0, e0, r;
        logic [7:0] b, prev_b;
        logic       stop;
        bit         flip;

        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        model_reset();
        repeat (5) @(posedge clk);
        #1;
        chk("rst.load", 32'(load), 0);
        chk("rst.err", 32'(frame_err), 0);
        chk("rst.x", 32'(load_x), 0);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        do_frame("press", 8'h1C, 1, 0);
        do_frame("ent_mk", 8'h5A, 1, 0);
        do_frame("ent_f0", 8'hF0, 1, 0);
        do_frame("ent_br", 8'h5A, 1, 0);
        do_frame("rep1", 8'h2B, 1, 0);
        do_frame("rep2", 8'h2B, 1, 0);
        do_frame("rep3", 8'h2B, 1, 0);
        do_frame("rep_f0", 8'hF0, 1, 0);
        do_frame("rep_br", 8'h2B, 1, 0);
        do_frame("rep4", 8'h2B, 1, 0);
        do_frame("ext_e0", 8'hE0, 1, 0);
        do_frame("ext_1c", 8'h1C, 1, 0);
        do_frame("unmap", 8'h76, 1, 0);
        do_frame("held2b", 8'h2B, 1, 0);
        do_frame("stop0", 8'h1C, 0, 0);

        l0 = loads_seen;
        e0 = errs_seen;
        ps2_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, 0);
        repeat (TIMEOUT / 2) @(posedge clk);
        #1 chk("to.early", errs_seen - e0, 0);
        repeat (TIMEOUT) @(posedge clk);
        #1;
        chk("to.err", errs_seen - e0, 1);
        chk("to.load", loads_seen - l0, 0);
        do_frame("to.next", 8'h1A, 1, 0);
        do_frame("parflip", 8'h1C, 1, 1);

        l0 = loads_seen;
        e0 = errs_seen;
        ps2_bit(1'b0, 0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b0, 0);
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        model_reset();
        repeat (20) @(posedge clk);
        #1;
        chk("mid.load", 32'(load), 0);
        chk("mid.err", 32'(frame_err), 0);
        chk("mid.x", 32'(load_x), 0);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("mid.nopulse", (loads_seen - l0) + (errs_seen - e0), 0);
        do_frame("mid.next", 8'h24, 1, 0);

        prev_b = 8'h24;
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                5:       b = 8'hF0;
                6:       b = 8'hE0;
                7:       b = 8'($urandom_range(0, 255));
                8:       b = prev_b;
                default: b = codes[$urandom_range(0, 26)];
            endcase
            stop = ($urandom_range(0, 15) != 0);
            flip = ($urandom_range(0, 15) == 0);
            do_frame("rand", b, stop, flip);
            prev_b = b;
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 40)) @(posedge clk);
                #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
